// File: rtl/cp0_exc.sv
// cp0_exc: exception commit and CP0 register file for the MIPS pipeline.
// Resolves MEM-stage exception flags, interrupts and ERET into a fetch
// redirect/flush, and keeps BadVAddr, Count, Compare, Status, Cause and EPC.
module cp0_exc #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] pc_mem,
  input  logic        in_ds_mem,
  input  logic        exc_if_adel,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic [2:0]  load_store_mem,
  input  logic        dm_addr_illegal,
  input  logic [31:0] data_addr,
  input  logic        eret_mem,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_waddr,
  input  logic [31:0] cp0_wdata,
  input  logic [4:0]  cp0_raddr,
  output logic [31:0] cp0_rdata,
  input  logic [5:0]  hw_int,
  output logic        exc_flush,
  output logic [31:0] exc_target
);

  // Only IM, EXL and IE are software writable; BEV and the rest keep reset value.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  logic [31:0] badvaddr_reg;
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic [31:0] status_reg;
  logic [31:0] status_next;
  logic [31:0] epc_reg;
  logic        cause_bd_reg;
  logic        cause_ti_reg;
  logic [7:0]  cause_ip_reg;
  logic [4:0]  cause_exccode_reg;
  logic        tick_reg;

  logic [31:0] cause_value;
  logic [5:0]  ip_hw_next;
  logic        int_req;
  logic        data_is_store;
  logic        exc_raw;
  logic [4:0]  exc_code;
  logic        bad_from_pc;
  logic        bad_from_data;
  logic        exc_take;
  logic        eret_take;
  logic        wr_take;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        ti_hit;

  assign cause_value = {cause_bd_reg, cause_ti_reg, 14'b0, cause_ip_reg,
                        1'b0, cause_exccode_reg, 2'b00};

  // Hardware IP bits: the timer shares line 5 with hw_int[5].
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_ip_hw
      if (gi == 5) begin : g_timer_line
        assign ip_hw_next[gi] = hw_int[gi] | cause_ti_reg;
      end else begin : g_plain_line
        assign ip_hw_next[gi] = hw_int[gi];
      end
    end
  endgenerate

  assign int_req = status_reg[0] & ~status_reg[1] &
                   (|(cause_ip_reg & status_reg[15:8]));

  assign data_is_store = load_store_mem[2] & (|load_store_mem[1:0]);

  // Prioritised exception selection and BadVAddr source.
  always_comb begin
    exc_raw       = 1'b1;
    exc_code      = 5'd0;
    bad_from_pc   = 1'b0;
    bad_from_data = 1'b0;
    if (int_req) begin
      exc_code = 5'd0;
    end else if (exc_if_adel) begin
      exc_code    = 5'd4;
      bad_from_pc = 1'b1;
    end else if (exc_ri) begin
      exc_code = 5'd10;
    end else if (exc_ov) begin
      exc_code = 5'd12;
    end else if (exc_sys) begin
      exc_code = 5'd8;
    end else if (exc_bp) begin
      exc_code = 5'd9;
    end else if (dm_addr_illegal) begin
      exc_code      = data_is_store ? 5'd5 : 5'd4;
      bad_from_data = 1'b1;
    end else begin
      exc_raw = 1'b0;
    end
  end

  assign exc_take   = mem_valid & exc_raw;
  assign eret_take  = mem_valid & eret_mem & ~exc_take;
  assign wr_take    = mem_valid & mtc0_we & ~exc_take;
  assign wr_count   = wr_take & (cp0_waddr == 5'd9);
  assign wr_compare = wr_take & (cp0_waddr == 5'd11);
  assign wr_status  = wr_take & (cp0_waddr == 5'd12);
  assign wr_cause   = wr_take & (cp0_waddr == 5'd13);
  assign wr_epc     = wr_take & (cp0_waddr == 5'd14);
  assign ti_hit     = (count_reg == compare_reg) & (compare_reg != 32'd0);

  assign exc_flush  = resetn & (exc_take | eret_take);
  assign exc_target = exc_take ? EXC_VECTOR : epc_reg;

  // MFC0 read port; unimplemented numbers read as zero.
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_raddr)
      5'd8:    cp0_rdata = badvaddr_reg;
      5'd9:    cp0_rdata = count_reg;
      5'd11:   cp0_rdata = compare_reg;
      5'd12:   cp0_rdata = status_reg;
      5'd13:   cp0_rdata = cause_value;
      5'd14:   cp0_rdata = epc_reg;
      default: cp0_rdata = 32'd0;
    endcase
  end

  // Status next value: exception sets EXL and blocks MTC0; ERET clears EXL.
  always_comb begin
    status_next = status_reg;
    if (exc_take) begin
      status_next[1] = 1'b1;
    end else begin
      if (wr_status) begin
        status_next = (status_reg & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
      end
      if (eret_take) begin
        status_next[1] = 1'b0;
      end
    end
  end

  // Count advances every second cycle; an MTC0 to Count takes precedence.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_reg  <= 1'b0;
      count_reg <= 32'd0;
    end else begin
      tick_reg <= ~tick_reg;
      if (wr_count) begin
        count_reg <= cp0_wdata;
      end else if (tick_reg) begin
        count_reg <= count_reg + 32'd1;
      end
    end
  end

  // Compare register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare_reg <= 32'd0;
    end else if (wr_compare) begin
      compare_reg <= cp0_wdata;
    end
  end

  // Status register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_reg <= STATUS_RESET;
    end else begin
      status_reg <= status_next;
    end
  end

  // Cause: IP sampling, sticky timer flag, exception code and delay-slot flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cause_bd_reg      <= 1'b0;
      cause_ti_reg      <= 1'b0;
      cause_ip_reg      <= 8'd0;
      cause_exccode_reg <= 5'd0;
    end else begin
      cause_ip_reg[7:2] <= ip_hw_next;
      if (wr_cause) begin
        cause_ip_reg[1:0] <= cp0_wdata[9:8];
      end
      cause_ti_reg <= wr_compare ? 1'b0 : (cause_ti_reg | ti_hit);
      if (exc_take) begin
        cause_bd_reg      <= in_ds_mem;
        cause_exccode_reg <= exc_code;
      end
    end
  end

  // EPC: the branch address when the faulting instruction is in a delay slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc_reg <= 32'd0;
    end else if (exc_take) begin
      epc_reg <= in_ds_mem ? (pc_mem - 32'd4) : pc_mem;
    end else if (wr_epc) begin
      epc_reg <= cp0_wdata;
    end
  end

  // BadVAddr: only address-error exceptions update it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      badvaddr_reg <= 32'd0;
    end else if (exc_take & bad_from_pc) begin
      badvaddr_reg <= pc_mem;
    end else if (exc_take & bad_from_data) begin
      badvaddr_reg <= data_addr;
    end
  end

endmodule

// File: tb/tb_cp0_exc.sv
// tb_cp0_exc: table vectors, directed corner sequences and random stimulus
// against a register-array reference model of cp0_exc.
module tb_cp0_exc;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic [31:0] pc_mem;
  logic        in_ds_mem;
  logic        exc_if_adel, exc_ri, exc_ov, exc_sys, exc_bp;
  logic [2:0]  load_store_mem;
  logic        dm_addr_illegal;
  logic [31:0] data_addr;
  logic        eret_mem;
  logic        mtc0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [5:0]  hw_int;
  logic        exc_flush;
  logic [31:0] exc_target;

  cp0_exc dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .pc_mem(pc_mem),
    .in_ds_mem(in_ds_mem), .exc_if_adel(exc_if_adel), .exc_ri(exc_ri),
    .exc_ov(exc_ov), .exc_sys(exc_sys), .exc_bp(exc_bp),
    .load_store_mem(load_store_mem), .dm_addr_illegal(dm_addr_illegal),
    .data_addr(data_addr), .eret_mem(eret_mem), .mtc0_we(mtc0_we),
    .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr),
    .cp0_rdata(cp0_rdata), .hw_int(hw_int), .exc_flush(exc_flush),
    .exc_target(exc_target)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_reg  [0:31];
  logic [31:0] m_mask [0:31];
  bit          m_impl [0:31];
  int          m_edges;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 32'd0; m_mask[i] = 32'd0; m_impl[i] = 1'b0;
    end
    m_reg[12] = 32'h0040_0000;
    m_mask[9] = 32'hFFFF_FFFF; m_mask[11] = 32'hFFFF_FFFF; m_mask[14] = 32'hFFFF_FFFF;
    m_mask[12] = 32'h0000_FF03; m_mask[13] = 32'h0000_0300;
    m_impl[8] = 1'b1; m_impl[9] = 1'b1; m_impl[11] = 1'b1;
    m_impl[12] = 1'b1; m_impl[13] = 1'b1; m_impl[14] = 1'b1;
    m_edges = 0;
  endfunction

  // First matching entry of the priority list wins; src 1 = pc, 2 = data addr.
  function automatic void exc_eval(output bit hit, output logic [4:0] code, output int src);
    bit          conds [7];
    logic [4:0]  codes [7];
    int          srcs  [7];
    bit          intr;
    intr = m_reg[12][0] && !m_reg[12][1] && ((m_reg[13][15:8] & m_reg[12][15:8]) != 8'd0);
    conds[0] = intr;        codes[0] = 5'd0;  srcs[0] = 0;
    conds[1] = exc_if_adel; codes[1] = 5'd4;  srcs[1] = 1;
    conds[2] = exc_ri;      codes[2] = 5'd10; srcs[2] = 0;
    conds[3] = exc_ov;      codes[3] = 5'd12; srcs[3] = 0;
    conds[4] = exc_sys;     codes[4] = 5'd8;  srcs[4] = 0;
    conds[5] = exc_bp;      codes[5] = 5'd9;  srcs[5] = 0;
    conds[6] = dm_addr_illegal;
    codes[6] = (load_store_mem >= 3'd5) ? 5'd5 : 5'd4; srcs[6] = 2;
    hit = 1'b0; code = 5'd0; src = 0;
    if (mem_valid) begin
      for (int i = 0; i < 7; i++) begin
        if (conds[i]) begin
          hit = 1'b1; code = codes[i]; src = srcs[i];
          break;
        end
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return m_impl[a] ? m_reg[a] : 32'd0;
  endfunction

  function automatic void model_step();
    logic [31:0] o [0:31];
    logic [31:0] n [0:31];
    bit hit, wr, er, tick, ti_old, ti_hit;
    logic [4:0] code;
    int src;
    o = m_reg; n = m_reg;
    exc_eval(hit, code, src);
    wr   = mem_valid && mtc0_we && !hit;
    er   = mem_valid && eret_mem && !hit;
    tick = (m_edges % 2) == 1;
    if (wr) n[cp0_waddr] = (o[cp0_waddr] & ~m_mask[cp0_waddr]) | (cp0_wdata & m_mask[cp0_waddr]);
    if (!(wr && cp0_waddr == 5'd9) && tick) n[9] = o[9] + 32'd1;
    ti_old = o[13][30];
    ti_hit = (o[9] == o[11]) && (o[11] != 32'd0);
    n[13][30] = (wr && cp0_waddr == 5'd11) ? 1'b0 : (ti_old | ti_hit);
    n[13][15:10] = {hw_int[5] | ti_old, hw_int[4:0]};
    if (hit) begin
      n[12][1] = 1'b1; n[13][6:2] = code; n[13][31] = in_ds_mem;
      n[14] = in_ds_mem ? pc_mem - 32'd4 : pc_mem;
      if (src == 1) n[8] = pc_mem;
      else if (src == 2) n[8] = data_addr;
    end
    if (er) n[12][1] = 1'b0;
    m_reg = n;
    m_edges++;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    mem_valid = 0; pc_mem = 0; in_ds_mem = 0; exc_if_adel = 0; exc_ri = 0;
    exc_ov = 0; exc_sys = 0; exc_bp = 0; load_store_mem = 0; dm_addr_illegal = 0;
    data_addr = 0; eret_mem = 0; mtc0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
    cp0_raddr = 0; hw_int = 0;
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    cp0_raddr = a;
    #1;
    v = cp0_rdata;
  endtask

  task automatic do_reset();
    drive_idle();
    resetn = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    resetn = 1;
    model_reset();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    drive_idle();
    mem_valid = 1; mtc0_we = 1; cp0_waddr = a; cp0_wdata = d;
    clk_step();
    drive_idle();
  endtask

  task automatic check_model_comb(input int cyc);
    bit hit; logic [4:0] code; int src; logic exp_flush;
    exc_eval(hit, code, src);
    exp_flush = hit | (mem_valid & eret_mem);
    check($sformatf("rnd%0d flush", cyc), 32'(exc_flush), 32'(exp_flush));
    if (exp_flush) check($sformatf("rnd%0d target", cyc), exc_target, hit ? VEC : m_reg[14]);
    check($sformatf("rnd%0d rdata[%0d]", cyc, cp0_raddr), cp0_rdata, model_read(cp0_raddr));
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic mv; logic [31:0] pc; logic ds, adel, ri, ov, sys, bp;
    logic [2:0] lsm; logic ill; logic [31:0] da;
    logic e_flush; logic [4:0] e_code; logic [31:0] e_epc, e_bad; logic e_bd;
  } vec_t;

  vec_t tbl [10];
  logic [31:0] v;
  logic [4:0]  wlist [8];

  initial begin
    tbl[0] = '{1'b1, 32'hBFC0_1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 32'h8000_0102, 1'b1, 5'd5,  32'hBFC0_1000, 32'h8000_0102, 1'b0};
    tbl[1] = '{1'b1, 32'hBFC0_2004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 32'h0000_0011, 1'b1, 5'd4,  32'hBFC0_2000, 32'h0000_0011, 1'b1};
    tbl[2] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1, 32'h0000_0033, 1'b1, 5'd8,  32'h0000_0100, 32'h0000_0000, 1'b0};
    tbl[3] = '{1'b1, 32'h0000_0102, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 5'd4,  32'h0000_0102, 32'h0000_0102, 1'b0};
    tbl[4] = '{1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 5'd10, 32'h0000_0200, 32'h0000_0000, 1'b0};
    tbl[5] = '{1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 5'd12, 32'h0000_0300, 32'h0000_0000, 1'b0};
    tbl[6] = '{1'b1, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 32'h0000_0000, 1'b1, 5'd9,  32'h0000_1FFC, 32'h0000_0000, 1'b1};
    tbl[7] = '{1'b0, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 32'h0000_0044, 1'b0, 5'd0,  32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[8] = '{1'b1, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1, 32'h0000_0046, 1'b1, 5'd4,  32'h0000_0500, 32'h0000_0046, 1'b0};
    tbl[9] = '{1'b1, 32'h0000_0600, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 32'h0000_0047, 1'b1, 5'd5,  32'h0000_05FC, 32'h0000_0047, 1'b1};
    wlist = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd20};

    // Reset state; flush is held low during reset even with a fault presented.
    drive_idle();
    resetn = 0;
    mem_valid = 1; exc_ri = 1;
    #3;
    check("reset flush", 32'(exc_flush), 32'd0);
    do_reset();
    rd(5'd12, v); check("reset status", v, 32'h0040_0000);
    rd(5'd13, v); check("reset cause", v, 32'd0);
    check("reset idle flush", 32'(exc_flush), 32'd0);

    // Table of single-cycle exception cases, each from reset.
    for (int i = 0; i < 10; i++) begin
      do_reset();
      mem_valid = tbl[i].mv; pc_mem = tbl[i].pc; in_ds_mem = tbl[i].ds;
      exc_if_adel = tbl[i].adel; exc_ri = tbl[i].ri; exc_ov = tbl[i].ov;
      exc_sys = tbl[i].sys; exc_bp = tbl[i].bp; load_store_mem = tbl[i].lsm;
      dm_addr_illegal = tbl[i].ill; data_addr = tbl[i].da;
      #3;
      check($sformatf("vec%0d flush", i), 32'(exc_flush), 32'(tbl[i].e_flush));
      if (tbl[i].e_flush) check($sformatf("vec%0d target", i), exc_target, VEC);
      clk_step();
      drive_idle();
      rd(5'd13, v);
      check($sformatf("vec%0d exccode", i), 32'(v[6:2]), 32'(tbl[i].e_code));
      check($sformatf("vec%0d bd", i), 32'(v[31]), 32'(tbl[i].e_bd));
      rd(5'd14, v); check($sformatf("vec%0d epc", i), v, tbl[i].e_epc);
      rd(5'd8, v);  check($sformatf("vec%0d badvaddr", i), v, tbl[i].e_bad);
      rd(5'd12, v); check($sformatf("vec%0d exl", i), 32'(v[1]), 32'(tbl[i].e_flush));
    end

    // ERET after an exception returns to EPC and clears EXL.
    do_reset();
    mem_valid = 1; exc_sys = 1; pc_mem = 32'h0000_0700;
    clk_step();
    drive_idle();
    mem_valid = 1; eret_mem = 1;
    #3;
    check("eret flush", 32'(exc_flush), 32'd1);
    check("eret target", exc_target, 32'h0000_0700);
    clk_step();
    drive_idle();
    rd(5'd12, v); check("eret exl", 32'(v[1]), 32'd0);

    // Exception and ERET together: exception wins.
    do_reset();
    mem_valid = 1; exc_ri = 1; eret_mem = 1; pc_mem = 32'h0000_0800;
    #3;
    check("exc+eret target", exc_target, VEC);
    clk_step();
    drive_idle();
    rd(5'd12, v); check("exc+eret exl", 32'(v[1]), 32'd1);
    rd(5'd14, v); check("exc+eret epc", v, 32'h0000_0800);

    // MTC0 suppressed by a same-cycle exception; MFC0 sees the old value.
    do_reset();
    mem_valid = 1; exc_ri = 1; pc_mem = 32'h0000_0900;
    mtc0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'h1234_5678;
    clk_step();
    drive_idle();
    rd(5'd14, v); check("suppressed mtc0 epc", v, 32'h0000_0900);
    mem_valid = 1; mtc0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hAAAA_0000;
    cp0_raddr = 5'd14;
    #3;
    check("mfc0 old value", cp0_rdata, 32'h0000_0900);
    clk_step();
    drive_idle();
    rd(5'd14, v); check("mfc0 new value", v, 32'hAAAA_0000);

    // Timer: Compare=4 at edge 1, Status at edge 2, Count hits 4 at edge 8.
    do_reset();
    mtc0(5'd11, 32'd4);
    mtc0(5'd12, 32'h0000_8001);
    for (int k = 0; k < 6; k++) clk_step();
    rd(5'd9, v);  check("timer count@8", v, 32'd4);
    rd(5'd13, v); check("timer ti@8", 32'(v[30]), 32'd0);
    clk_step();
    rd(5'd13, v); check("timer ti@9", 32'(v[30]), 32'd1);
    rd(5'd12, v); check("timer status", v, 32'h0040_8001);
    clk_step();
    // Interrupt outranks the data address error; BadVAddr must stay put.
    mem_valid = 1; pc_mem = 32'h0000_0A00; dm_addr_illegal = 1;
    load_store_mem = 3'd7; data_addr = 32'h0000_DEAD;
    #3;
    check("timer int flush", 32'(exc_flush), 32'd1);
    check("timer int target", exc_target, VEC);
    clk_step();
    drive_idle();
    rd(5'd13, v); check("timer int exccode", 32'(v[6:2]), 32'd0);
    rd(5'd8, v);  check("timer int badvaddr", v, 32'd0);
    rd(5'd14, v); check("timer int epc", v, 32'h0000_0A00);
    mtc0(5'd11, 32'h0000_0100);
    rd(5'd13, v); check("timer ti cleared", 32'(v[30]), 32'd0);

    // Asynchronous reset mid-cycle restores registers without a clock edge.
    mem_valid = 1; dm_addr_illegal = 1;
    #2;
    resetn = 0;
    #1;
    check("async reset flush", 32'(exc_flush), 32'd0);
    rd(5'd12, v); check("async reset status", v, 32'h0040_0000);
    rd(5'd11, v); check("async reset compare", v, 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      mem_valid       = ($urandom_range(0, 9) < 8);
      pc_mem          = $urandom;
      in_ds_mem       = 1'($urandom_range(0, 1));
      exc_if_adel     = ($urandom_range(0, 15) == 0);
      exc_ri          = ($urandom_range(0, 15) == 0);
      exc_ov          = ($urandom_range(0, 15) == 0);
      exc_sys         = ($urandom_range(0, 15) == 0);
      exc_bp          = ($urandom_range(0, 15) == 0);
      load_store_mem  = 3'($urandom_range(0, 7));
      dm_addr_illegal = ($urandom_range(0, 7) == 0);
      data_addr       = $urandom;
      eret_mem        = ($urandom_range(0, 11) == 0);
      mtc0_we         = !eret_mem && ($urandom_range(0, 3) == 0);
      cp0_waddr       = wlist[$urandom_range(0, 7)];
      case (cp0_waddr)
        5'd9:    cp0_wdata = 32'($urandom_range(0, 60));
        5'd11:   cp0_wdata = 32'($urandom_range(1, 400));
        5'd12:   cp0_wdata = ($urandom_range(0, 1) == 1) ? 32'h0000_FF01 : $urandom;
        default: cp0_wdata = $urandom;
      endcase
      hw_int          = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      cp0_raddr       = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : wlist[$urandom_range(0, 5)];
      #3;
      check_model_comb(c);
      clk_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
